// File: rtl/ahb_pkg.sv
// ---------------------------------------------------------------------------
// ahb_pkg
// Shared AHB-Lite encodings for the memory slave and its bench:
// transfer types, transfer sizes, burst types, response codes and the
// slave's data-phase state type.
// No ports (package).
// ---------------------------------------------------------------------------
package ahb_pkg;

  // HTRANS codes
  localparam logic [1:0] HTRANS_IDLE   = 2'd0;
  localparam logic [1:0] HTRANS_BUSY   = 2'd1;
  localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
  localparam logic [1:0] HTRANS_SEQ    = 2'd3;

  // HSIZE codes
  localparam logic [2:0] HSIZE_BYTE  = 3'd0;
  localparam logic [2:0] HSIZE_HALF  = 3'd1;
  localparam logic [2:0] HSIZE_WORD  = 3'd2;
  localparam logic [2:0] HSIZE_DWORD = 3'd3;

  // HBURST codes (informational only for this slave)
  localparam logic [2:0] HBURST_SINGLE = 3'd0;
  localparam logic [2:0] HBURST_INCR   = 3'd1;
  localparam logic [2:0] HBURST_WRAP4  = 3'd2;
  localparam logic [2:0] HBURST_INCR4  = 3'd3;
  localparam logic [2:0] HBURST_WRAP8  = 3'd4;
  localparam logic [2:0] HBURST_INCR8  = 3'd5;
  localparam logic [2:0] HBURST_WRAP16 = 3'd6;
  localparam logic [2:0] HBURST_INCR16 = 3'd7;

  // HRESP codes
  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // Data-phase state of the slave
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_DATA = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } ahb_state_e;

endpackage

// File: rtl/ahb_byte_ram.sv
// ---------------------------------------------------------------------------
// ahb_byte_ram
// DEPTH x DATA_W storage with one byte-enabled synchronous write port and
// one asynchronous read port. Contents are not reset.
// Ports:
//   clk    in   write clock
//   we     in   write enable
//   be     in   per-byte write enables (bit i -> bits [8i+7:8i])
//   waddr  in   write word index
//   wdata  in   write data
//   raddr  in   read word index
//   rdata  out  read data (combinational)
// ---------------------------------------------------------------------------
module ahb_byte_ram #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  localparam int NB    = DATA_W / 8,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [NB-1:0]     be,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Byte-lane write port; storage deliberately has no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (we && be[i]) begin
        mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ahb_slave_mem.sv
// ---------------------------------------------------------------------------
// ahb_slave_mem
// Parametrised AHB-Lite memory slave with configurable wait states,
// byte/halfword lanes and a two-cycle ERROR response. Bursts are served
// beat by beat from the master-supplied addresses.
// Ports:
//   HCLK    in   bus clock
//   HRESET  in   synchronous active-high reset
//   HSEL    in   slave select
//   HADDR   in   byte address
//   HWRITE  in   1 = write
//   HSIZE   in   transfer size
//   HBURST  in   burst type (unused)
//   HTRANS  in   transfer type
//   HWDATA  in   write data, sampled on the completing edge
//   HREADY  out  ready; also gates this slave's address sampling
//   HRESP   out  0 = OKAY, 1 = ERROR
//   HRDATA  out  read data, non-zero only in a read's completing cycle
// ---------------------------------------------------------------------------
module ahb_slave_mem
  import ahb_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              HSEL,
  input  logic [ADDR_W-1:0] HADDR,
  input  logic              HWRITE,
  input  logic [2:0]        HSIZE,
  input  logic [2:0]        HBURST,
  input  logic [1:0]        HTRANS,
  input  logic [DATA_W-1:0] HWDATA,
  output logic              HREADY,
  output logic              HRESP,
  output logic [DATA_W-1:0] HRDATA
);

  localparam int          NB        = DATA_W / 8;
  localparam int          LANE_W    = $clog2(NB);
  localparam int          IDX_W     = $clog2(DEPTH);
  localparam logic [63:0] MEM_BYTES = 64'(DEPTH) * 64'(NB);
  localparam logic [3:0]  WAIT_LAST = 4'(WAIT_STATES);
  localparam logic [2:0]  MAX_SIZE  = 3'(LANE_W);

  ahb_state_e        state;
  logic [3:0]        wait_cnt;
  logic [ADDR_W-1:0] dp_addr;
  logic              dp_write;
  logic [2:0]        dp_size;

  logic              accept;
  logic              illegal;
  logic [7:0]        align_mask;
  logic [NB-1:0]     lane_be;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;
  logic              unused_ok;

  // Byte enables for a transfer of 2^size bytes starting at lane 'offset'.
  function automatic logic [NB-1:0] lane_enables(input logic [2:0] size,
                                                 input logic [LANE_W-1:0] offset);
    logic [15:0] span;
    span = (16'd1 << (16'd1 << size)) - 16'd1;
    return NB'(span) << offset;
  endfunction

  // HREADY is our own registered output, so no address is taken while stalled.
  assign accept = HREADY && HSEL &&
                  ((HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ));

  assign align_mask = (8'd1 << HSIZE) - 8'd1;
  assign illegal    = (64'(HADDR) >= MEM_BYTES) ||
                      (HSIZE > MAX_SIZE) ||
                      ((HADDR[7:0] & align_mask) != 8'd0);

  // Only legal transfers reach DATA, so dp_addr is in range there.
  assign lane_be = lane_enables(dp_size, dp_addr[LANE_W-1:0]);
  // A reset on the completing edge drops the pending write.
  assign mem_we  = (state == ST_DATA) && dp_write && !HRESET;
  assign HRDATA  = ((state == ST_DATA) && !dp_write) ? mem_rdata : {DATA_W{1'b0}};

  assign unused_ok = ^{HBURST, dp_addr};

  // Data-phase FSM with registered HREADY/HRESP.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state    <= ST_IDLE;
      wait_cnt <= 4'd0;
      HREADY   <= 1'b1;
      HRESP    <= HRESP_OKAY;
      dp_addr  <= {ADDR_W{1'b0}};
      dp_write <= 1'b0;
      dp_size  <= 3'd0;
    end else begin
      case (state)
        ST_IDLE, ST_DATA, ST_ERR2: begin
          if (accept) begin
            dp_addr  <= HADDR;
            dp_write <= HWRITE;
            dp_size  <= HSIZE;
            if (illegal) begin
              state  <= ST_ERR1;
              HREADY <= 1'b0;
              HRESP  <= HRESP_ERROR;
            end else if (WAIT_STATES > 0) begin
              state    <= ST_WAIT;
              wait_cnt <= 4'd1;
              HREADY   <= 1'b0;
              HRESP    <= HRESP_OKAY;
            end else begin
              state  <= ST_DATA;
              HREADY <= 1'b1;
              HRESP  <= HRESP_OKAY;
            end
          end else begin
            state  <= ST_IDLE;
            HREADY <= 1'b1;
            HRESP  <= HRESP_OKAY;
          end
        end
        ST_WAIT: begin
          // wait_cnt counts the HREADY-low cycles already spent.
          if (wait_cnt == WAIT_LAST) begin
            state    <= ST_DATA;
            wait_cnt <= 4'd0;
            HREADY   <= 1'b1;
            HRESP    <= HRESP_OKAY;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        ST_ERR1: begin
          state  <= ST_ERR2;
          HREADY <= 1'b1;
          HRESP  <= HRESP_ERROR;
        end
        default: begin
          state    <= ST_IDLE;
          wait_cnt <= 4'd0;
          HREADY   <= 1'b1;
          HRESP    <= HRESP_OKAY;
        end
      endcase
    end
  end

  ahb_byte_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk   (HCLK),
    .we    (mem_we),
    .be    (lane_be),
    .waddr (dp_addr[LANE_W +: IDX_W]),
    .wdata (HWDATA),
    .raddr (dp_addr[LANE_W +: IDX_W]),
    .rdata (mem_rdata)
  );

endmodule

// File: tb/tb_ahb_slave_mem.sv
// ---------------------------------------------------------------------------
// tb_ahb_slave_mem
// Two slaves (0 and 2 wait states) driven by a pipelined AHB master model.
// Expected bus behaviour comes from a byte-array memory model and the
// transfer rules (legality, latency = 1 + wait states, two-cycle ERROR).
// ---------------------------------------------------------------------------
module tb_ahb_slave_mem;
  import ahb_pkg::*;

  localparam int DEPTH     = 256;
  localparam int MEM_BYTES = DEPTH * 4;
  localparam int WS0       = 0;
  localparam int WS1       = 2;

  typedef struct {
    logic        sel;
    logic [1:0]  trans;
    logic [31:0] addr;
    logic        write;
    logic [2:0]  size;
    logic [2:0]  burst;
    logic [31:0] data;
  } txn_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        hreset [2];
  logic        hsel   [2];
  logic [31:0] haddr  [2];
  logic        hwrite [2];
  logic [2:0]  hsize  [2];
  logic [2:0]  hburst [2];
  logic [1:0]  htrans [2];
  logic [31:0] hwdata [2];
  logic        hready [2];
  logic        hresp  [2];
  logic [31:0] hrdata [2];

  txn_t       txq [$];
  logic [7:0] mref [2][MEM_BYTES];
  int         n_cmp = 0;
  int         n_bad = 0;

  ahb_slave_mem #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH), .WAIT_STATES(WS0)) dut_ws0 (
    .HCLK(clk), .HRESET(hreset[0]), .HSEL(hsel[0]), .HADDR(haddr[0]), .HWRITE(hwrite[0]),
    .HSIZE(hsize[0]), .HBURST(hburst[0]), .HTRANS(htrans[0]), .HWDATA(hwdata[0]),
    .HREADY(hready[0]), .HRESP(hresp[0]), .HRDATA(hrdata[0]));

  ahb_slave_mem #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH), .WAIT_STATES(WS1)) dut_ws2 (
    .HCLK(clk), .HRESET(hreset[1]), .HSEL(hsel[1]), .HADDR(haddr[1]), .HWRITE(hwrite[1]),
    .HSIZE(hsize[1]), .HBURST(hburst[1]), .HTRANS(htrans[1]), .HWDATA(hwdata[1]),
    .HREADY(hready[1]), .HRESP(hresp[1]), .HRDATA(hrdata[1]));

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // A transfer errors when out of range, wider than the bus, or misaligned.
  function automatic bit is_error(input txn_t t);
    return (t.addr >= 32'(MEM_BYTES)) || (t.size > 3'd2) ||
           ((t.addr % (32'd1 << t.size)) != 32'd0);
  endfunction

  function automatic logic [31:0] model_read(input int d, input logic [31:0] addr);
    int b;
    b = int'(addr) & ~3;
    return {mref[d][b+3], mref[d][b+2], mref[d][b+1], mref[d][b]};
  endfunction

  // Each byte of the transfer is taken from its little-endian lane of HWDATA.
  task automatic model_write(input int d, input txn_t t);
    int a;
    for (int i = 0; i < (1 << t.size); i++) begin
      a = int'(t.addr) + i;
      mref[d][a] = t.data[8*(a%4) +: 8];
    end
  endtask

  task automatic push(input logic sel, input logic [1:0] trans, input logic [31:0] addr,
                      input logic wr, input logic [2:0] size, input logic [2:0] burst,
                      input logic [31:0] data);
    txn_t t;
    t.sel = sel; t.trans = trans; t.addr = addr; t.write = wr;
    t.size = size; t.burst = burst; t.data = data;
    txq.push_back(t);
  endtask

  task automatic drive_idle(input int d);
    hsel[d]   = 1'b0;
    htrans[d] = HTRANS_IDLE;
    haddr[d]  = $urandom();
    hwrite[d] = 1'($urandom_range(0, 1));
    hsize[d]  = HSIZE_WORD;
    hburst[d] = HBURST_SINGLE;
  endtask

  // Pipelined master: drains txq into slave d, checking every cycle.
  task automatic run_queue(input int d, input int ws);
    bit          dp_v;
    bit          dp_err;
    bit          done;
    bit          chk_rd;
    txn_t        dp;
    txn_t        t;
    int          k;
    int          guard;
    logic        exp_rdy;
    logic        exp_resp;
    logic [31:0] exp_rd;
    dp_v = 1'b0; dp_err = 1'b0; k = 0; guard = 0;
    while ((txq.size() > 0 || dp_v) && guard < 5000) begin
      @(negedge clk);
      guard++;
      exp_rdy = 1'b1; exp_resp = 1'b0; exp_rd = 32'd0; chk_rd = 1'b1; done = 1'b0;
      if (dp_v) begin
        if (dp_err) begin
          exp_resp = 1'b1;
          done     = (k == 1);
          exp_rdy  = done;
        end else begin
          done    = (k == ws);
          exp_rdy = done;
          if (done && dp.write) chk_rd = 1'b0;
          if (done && !dp.write) exp_rd = model_read(d, dp.addr);
        end
      end
      check_eq($sformatf("d%0d hready a=%h", d, dp.addr), 32'(hready[d]), 32'(exp_rdy));
      check_eq($sformatf("d%0d hresp a=%h", d, dp.addr), 32'(hresp[d]), 32'(exp_resp));
      if (chk_rd) check_eq($sformatf("d%0d hrdata a=%h", d, dp.addr), hrdata[d], exp_rd);
      hwdata[d] = (dp_v && done && dp.write) ? dp.data : $urandom();
      if (exp_rdy) begin
        if (dp_v && !dp_err && dp.write) model_write(d, dp);
        dp_v = 1'b0;
        if (txq.size() > 0) begin
          t = txq.pop_front();
          hsel[d] = t.sel; htrans[d] = t.trans; haddr[d] = t.addr;
          hwrite[d] = t.write; hsize[d] = t.size; hburst[d] = t.burst;
          if (t.sel && t.trans[1]) begin
            dp_v = 1'b1; dp = t; dp_err = is_error(t); k = 0;
          end
        end else begin
          drive_idle(d);
        end
      end else begin
        // Junk address phase while stalled must be ignored by the slave.
        k++;
        hsel[d]   = 1'b1;
        htrans[d] = HTRANS_NONSEQ;
        haddr[d]  = $urandom_range(0, MEM_BYTES - 1) & ~32'd3;
        hwrite[d] = 1'($urandom_range(0, 1));
        hsize[d]  = HSIZE_WORD;
      end
    end
    check_eq($sformatf("d%0d queue drained", d), 32'(txq.size()) + 32'(dp_v), 32'd0);
  endtask

  task automatic directed(input int d);
    push(1'b0, HTRANS_NONSEQ, 32'h14, 1'b1, HSIZE_WORD, HBURST_SINGLE, 32'h5555_5555);
    push(1'b1, HTRANS_IDLE,   32'h14, 1'b1, HSIZE_WORD, HBURST_SINGLE, 32'h5555_5555);
    push(1'b1, HTRANS_BUSY,   32'h14, 1'b1, HSIZE_WORD, HBURST_SINGLE, 32'h5555_5555);
    push(1'b1, HTRANS_NONSEQ, 32'h14, 1'b1, HSIZE_WORD, HBURST_SINGLE, 32'h1234_1234);
    push(1'b1, HTRANS_NONSEQ, 32'h14, 1'b0, HSIZE_WORD, HBURST_SINGLE, 32'h0);
    push(1'b1, HTRANS_NONSEQ, 32'h14, 1'b1, HSIZE_WORD, HBURST_WRAP4, 32'h1);
    push(1'b1, HTRANS_SEQ,    32'h18, 1'b1, HSIZE_WORD, HBURST_WRAP4, 32'h1234_1234);
    push(1'b1, HTRANS_SEQ,    32'h1C, 1'b1, HSIZE_WORD, HBURST_WRAP4, 32'h2);
    push(1'b1, HTRANS_SEQ,    32'h10, 1'b1, HSIZE_WORD, HBURST_WRAP4, 32'h3);
    push(1'b1, HTRANS_NONSEQ, 32'h10, 1'b0, HSIZE_WORD, HBURST_INCR4, 32'h0);
    push(1'b1, HTRANS_SEQ,    32'h14, 1'b0, HSIZE_WORD, HBURST_INCR4, 32'h0);
    push(1'b1, HTRANS_SEQ,    32'h18, 1'b0, HSIZE_WORD, HBURST_INCR4, 32'h0);
    push(1'b1, HTRANS_SEQ,    32'h1C, 1'b0, HSIZE_WORD, HBURST_INCR4, 32'h0);
    push(1'b1, HTRANS_NONSEQ, 32'h20, 1'b1, HSIZE_WORD, HBURST_SINGLE, 32'h0);
    push(1'b1, HTRANS_NONSEQ, 32'h21, 1'b1, HSIZE_BYTE, HBURST_SINGLE, 32'h0000_AB00);
    push(1'b1, HTRANS_NONSEQ, 32'h22, 1'b1, HSIZE_HALF, HBURST_SINGLE, 32'hCDEF_0000);
    push(1'b1, HTRANS_NONSEQ, 32'h20, 1'b0, HSIZE_WORD, HBURST_SINGLE, 32'h0);
    push(1'b1, HTRANS_NONSEQ, 32'(MEM_BYTES), 1'b0, HSIZE_WORD, HBURST_SINGLE, 32'h0);
    push(1'b1, HTRANS_NONSEQ, 32'h02, 1'b1, HSIZE_WORD, HBURST_SINGLE, 32'hFFFF_FFFF);
    push(1'b1, HTRANS_NONSEQ, 32'h00, 1'b0, HSIZE_WORD, HBURST_SINGLE, 32'h0);
    run_queue(d, (d == 0) ? WS0 : WS1);
    // Independent spot check of the lane-merge scenario.
    check_eq($sformatf("d%0d model 0x20", d), model_read(d, 32'h20), 32'hCDEF_AB00);
  endtask

  task automatic gen_random(input int n);
    int          kind;
    logic [2:0]  sz;
    logic [31:0] a;
    for (int i = 0; i < n; i++) begin
      kind = $urandom_range(0, 9);
      sz   = ($urandom_range(0, 15) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
      a    = $urandom_range(0, MEM_BYTES + 15);
      if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 32'd1);
      if (kind == 0) begin
        push(1'b0, HTRANS_NONSEQ, a, 1'b1, sz, HBURST_SINGLE, $urandom());
      end else if (kind == 1) begin
        push(1'b1, 2'($urandom_range(0, 1)), a, 1'b1, sz, HBURST_INCR, $urandom());
      end else begin
        push(1'b1, (kind > 5) ? HTRANS_SEQ : HTRANS_NONSEQ, a,
             1'($urandom_range(0, 1)), sz, HBURST_INCR, $urandom());
      end
    end
  endtask

  // Reset during a wait state drops the write and restores reset outputs.
  task automatic reset_in_wait();
    @(negedge clk);
    hsel[1] = 1'b1; htrans[1] = HTRANS_NONSEQ; haddr[1] = 32'h40;
    hwrite[1] = 1'b1; hsize[1] = HSIZE_WORD; hwdata[1] = 32'hDEAD_BEEF;
    @(negedge clk);
    check_eq("d1 hready in wait", 32'(hready[1]), 32'd0);
    drive_idle(1);
    hreset[1] = 1'b1;
    @(negedge clk);
    hreset[1] = 1'b0;
    check_eq("d1 rst hready", 32'(hready[1]), 32'd1);
    check_eq("d1 rst hresp", 32'(hresp[1]), 32'd0);
    check_eq("d1 rst hrdata", hrdata[1], 32'd0);
    push(1'b1, HTRANS_NONSEQ, 32'h40, 1'b0, HSIZE_WORD, HBURST_SINGLE, 32'h0);
    run_queue(1, WS1);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      hreset[d] = 1'b1;
      hwdata[d] = 32'd0;
      drive_idle(d);
    end
    @(negedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check_eq($sformatf("d%0d reset hready", d), 32'(hready[d]), 32'd1);
      check_eq($sformatf("d%0d reset hresp", d), 32'(hresp[d]), 32'd0);
      check_eq($sformatf("d%0d reset hrdata", d), hrdata[d], 32'd0);
      hreset[d] = 1'b0;
    end
    for (int d = 0; d < 2; d++) begin
      for (int w = 0; w < DEPTH; w++) begin
        push(1'b1, (w == 0) ? HTRANS_NONSEQ : HTRANS_SEQ, 32'(w * 4), 1'b1,
             HSIZE_WORD, HBURST_INCR, 32'h0);
      end
      run_queue(d, (d == 0) ? WS0 : WS1);
      directed(d);
      gen_random(250);
      run_queue(d, (d == 0) ? WS0 : WS1);
    end
    reset_in_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
